// File: rtl/pipe_ctrl_pkg.sv
// Shared types and defaults for the pipeline control block.
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    ABORT    = 2'd2
  } ctrl_state_e;

  localparam int TIMEOUT_CYC_DEF = 255;
  localparam int CNT_W_DEF       = 16;

endpackage

// File: rtl/pipe_hazard_det.sv
// Load-use hazard comparator between the load in EX and the sources of the instruction in ID.
module pipe_hazard_det (
  input  logic [4:0] i_rs1_addr,
  input  logic [4:0] i_rs2_addr,
  input  logic [4:0] i_rd_addr,
  input  logic       i_is_load,
  input  logic       i_rd_wren,
  output logic       o_load_use
);

  logic rd_live_s;
  logic src_match_s;

  // x0 is hardwired to zero, so a load targeting it can never create a dependency.
  always_comb begin
    rd_live_s   = i_is_load & i_rd_wren & (i_rd_addr != 5'd0);
    src_match_s = (i_rd_addr == i_rs1_addr) | (i_rd_addr == i_rs2_addr);
    o_load_use  = rd_live_s & src_match_s;
  end

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline stall/flush controller: memory-wait FSM with timeout, load-use and branch handling.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF,
  parameter int CNT_W       = CNT_W_DEF
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [4:0]       i_id_rs1_addr,
  input  logic [4:0]       i_id_rs2_addr,
  input  logic [4:0]       i_ex_rd_addr,
  input  logic             i_ex_is_load,
  input  logic             i_ex_rd_wren,
  input  logic             i_ex_br_taken,
  input  logic             i_mem_req,
  input  logic             i_mem_ack,
  output logic             o_pc_en,
  output logic             o_ifid_en,
  output logic             o_ifid_flush,
  output logic             o_idex_en,
  output logic             o_idex_flush,
  output logic             o_exmem_en,
  output logic             o_memwb_sel,
  output logic             o_mem_timeout,
  output logic [CNT_W-1:0] o_stall_cnt
);

  localparam int WAIT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT_CYC - 1);
  localparam logic [CNT_W-1:0]  CNT_MAX   = {CNT_W{1'b1}};

  ctrl_state_e       state_r;
  ctrl_state_e       state_nxt_s;
  logic [WAIT_W-1:0] wait_cnt_r;
  logic [WAIT_W-1:0] wait_nxt_s;
  logic [CNT_W-1:0]  stall_cnt_r;
  logic              load_use_s;
  logic              mem_stall_s;

  pipe_hazard_det u_hazard (
    .i_rs1_addr (i_id_rs1_addr),
    .i_rs2_addr (i_id_rs2_addr),
    .i_rd_addr  (i_ex_rd_addr),
    .i_is_load  (i_ex_is_load),
    .i_rd_wren  (i_ex_rd_wren),
    .o_load_use (load_use_s)
  );

  // Next-state and wait-counter logic; the counter is only meaningful inside MEM_WAIT.
  always_comb begin
    state_nxt_s = state_r;
    wait_nxt_s  = {WAIT_W{1'b0}};
    case (state_r)
      RUN: begin
        if (i_mem_req && !i_mem_ack) begin
          state_nxt_s = MEM_WAIT;
        end else begin
          state_nxt_s = RUN;
        end
      end
      MEM_WAIT: begin
        if (i_mem_ack) begin
          state_nxt_s = RUN;
        end else if (wait_cnt_r == WAIT_LAST) begin
          state_nxt_s = ABORT;
        end else begin
          state_nxt_s = MEM_WAIT;
          wait_nxt_s  = wait_cnt_r + WAIT_W'(1);
        end
      end
      ABORT:   state_nxt_s = RUN;
      default: state_nxt_s = RUN;
    endcase
  end

  // State and wait-counter registers.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_r    <= RUN;
      wait_cnt_r <= {WAIT_W{1'b0}};
    end else begin
      state_r    <= state_nxt_s;
      wait_cnt_r <= wait_nxt_s;
    end
  end

  // Output decode in priority order: reset, memory stall, abort, branch, load-use, normal.
  always_comb begin
    mem_stall_s   = ((state_r == RUN) && i_mem_req && !i_mem_ack) ||
                    ((state_r == MEM_WAIT) && !i_mem_ack);
    o_pc_en       = 1'b1;
    o_ifid_en     = 1'b1;
    o_ifid_flush  = 1'b0;
    o_idex_en     = 1'b1;
    o_idex_flush  = 1'b0;
    o_exmem_en    = 1'b1;
    o_memwb_sel   = 1'b0;
    o_mem_timeout = 1'b0;
    if (i_rst) begin
      o_pc_en      = 1'b0;
      o_ifid_en    = 1'b0;
      o_idex_en    = 1'b0;
      o_exmem_en   = 1'b0;
      o_ifid_flush = 1'b1;
      o_idex_flush = 1'b1;
      o_memwb_sel  = 1'b1;
    end else if (mem_stall_s) begin
      o_pc_en     = 1'b0;
      o_ifid_en   = 1'b0;
      o_idex_en   = 1'b0;
      o_exmem_en  = 1'b0;
      o_memwb_sel = 1'b1;
    end else if (state_r == ABORT) begin
      // The aborted access is dropped, but a resolving branch must still squash its shadow.
      o_memwb_sel   = 1'b1;
      o_mem_timeout = 1'b1;
      o_ifid_flush  = i_ex_br_taken;
      o_idex_flush  = i_ex_br_taken;
    end else if (i_ex_br_taken) begin
      o_ifid_flush = 1'b1;
      o_idex_flush = 1'b1;
    end else if (load_use_s) begin
      o_pc_en      = 1'b0;
      o_ifid_en    = 1'b0;
      o_idex_flush = 1'b1;
    end else begin
      o_pc_en = 1'b1;
    end
  end

  // Saturating count of frozen-PC cycles.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      stall_cnt_r <= {CNT_W{1'b0}};
    end else if (!o_pc_en && (stall_cnt_r != CNT_MAX)) begin
      stall_cnt_r <= stall_cnt_r + CNT_W'(1);
    end else begin
      stall_cnt_r <= stall_cnt_r;
    end
  end

  assign o_stall_cnt = stall_cnt_r;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Scoreboard bench for pipe_ctrl: a spec-level model pushes expected outputs, DUT outputs are popped and compared.
module tb_pipe_ctrl;

  localparam int TO    = 4;
  localparam int CW    = 3;

  typedef struct packed {
    logic [7:0]    flags;
    logic [CW-1:0] cnt;
    logic          cnt_vld;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst;
  logic [4:0]    rs1, rs2, rd;
  logic          ld, wr, br, req, ack;
  logic          pc_en, ifid_en, ifid_fl, idex_en, idex_fl, exmem_en, memwb_sel, tmo;
  logic [CW-1:0] stall_cnt;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_mis = 0;

  // Reference model state: 0 = run, 1 = waiting, 2 = abort.
  int            m_st   = 0;
  int            m_wait = 0;
  logic [CW-1:0] m_cnt  = '0;
  logic          m_vld  = 1'b0;

  always #5 clk = ~clk;

  pipe_ctrl #(.TIMEOUT_CYC(TO), .CNT_W(CW)) dut (
    .i_clk         (clk),
    .i_rst         (rst),
    .i_id_rs1_addr (rs1),
    .i_id_rs2_addr (rs2),
    .i_ex_rd_addr  (rd),
    .i_ex_is_load  (ld),
    .i_ex_rd_wren  (wr),
    .i_ex_br_taken (br),
    .i_mem_req     (req),
    .i_mem_ack     (ack),
    .o_pc_en       (pc_en),
    .o_ifid_en     (ifid_en),
    .o_ifid_flush  (ifid_fl),
    .o_idex_en     (idex_en),
    .o_idex_flush  (idex_fl),
    .o_exmem_en    (exmem_en),
    .o_memwb_sel   (memwb_sel),
    .o_mem_timeout (tmo),
    .o_stall_cnt   (stall_cnt)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // flags = {pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en, memwb_sel, timeout}
  function automatic logic [7:0] model_flags();
    logic lu;
    logic mstall;
    lu     = ld && wr && (rd != 5'd0) && ((rd == rs1) || (rd == rs2));
    mstall = ((m_st == 0) && req && !ack) || ((m_st == 1) && !ack);
    if (rst)            return 8'b0010_1010;
    else if (mstall)    return 8'b0000_0010;
    else if (m_st == 2) return {2'b11, br, 1'b1, br, 3'b111};
    else if (br)        return 8'b1111_1100;
    else if (lu)        return 8'b0001_1100;
    else                return 8'b1101_0100;
  endfunction

  task automatic model_step(input logic [7:0] f);
    if (rst) begin
      m_st = 0; m_wait = 0; m_cnt = '0; m_vld = 1'b1;
    end else begin
      if (!f[7] && (m_cnt != {CW{1'b1}})) m_cnt = m_cnt + 1'b1;
      case (m_st)
        0: if (req && !ack) begin m_st = 1; m_wait = 0; end
        1: begin
          if (ack) m_st = 0;
          else if (m_wait == TO - 1) m_st = 2;
          else m_wait++;
        end
        default: m_st = 0;
      endcase
    end
  endtask

  task automatic cyc(input logic r, input logic [4:0] a1, input logic [4:0] a2, input logic [4:0] d,
                     input logic l, input logic w, input logic b, input logic q, input logic k);
    exp_t e;
    exp_t o;
    @(negedge clk);
    rst = r; rs1 = a1; rs2 = a2; rd = d; ld = l; wr = w; br = b; req = q; ack = k;
    e.flags = model_flags(); e.cnt = m_cnt; e.cnt_vld = m_vld;
    exp_q.push_back(e);
    #1;
    o = exp_q.pop_front();
    check_eq("ctrl_flags", {pc_en, ifid_en, ifid_fl, idex_en, idex_fl, exmem_en, memwb_sel, tmo}, o.flags);
    if (o.cnt_vld) check_eq("stall_cnt", stall_cnt, o.cnt);
    model_step(o.flags);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 5'd1, 5'd2, 5'd3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    rst = 1'b1; rs1 = '0; rs2 = '0; rd = '0; ld = 1'b0; wr = 1'b0; br = 1'b0; req = 1'b0; ack = 1'b0;
    cyc(1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    idle(2);
    // load-use: lw x5 in EX, add x6,x5,x1 in ID
    cyc(1'b0, 5'd5, 5'd1, 5'd5, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    idle(1);
    // load-use on rs2, then non-writing load and x0 load
    cyc(1'b0, 5'd7, 5'd9, 5'd9, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 5'd9, 5'd9, 5'd9, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    // memory wait, ack on the fourth cycle
    for (int i = 0; i < 3; i++) cyc(1'b0, 5'd1, 5'd2, 5'd3, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    cyc(1'b0, 5'd1, 5'd2, 5'd3, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    // immediate ack, branch with load-use, branch under memory stall
    cyc(1'b0, 5'd1, 5'd2, 5'd3, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    cyc(1'b0, 5'd5, 5'd1, 5'd5, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    cyc(1'b0, 5'd1, 5'd2, 5'd3, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    cyc(1'b0, 5'd1, 5'd2, 5'd3, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
    // timeout: no ack until abort, then back in RUN
    cyc(1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < TO + 1; i++) cyc(1'b0, 5'd1, 5'd2, 5'd3, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    cyc(1'b0, 5'd1, 5'd2, 5'd3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    idle(1);
    // reset in the middle of a wait
    for (int i = 0; i < 2; i++) cyc(1'b0, 5'd1, 5'd2, 5'd3, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    cyc(1'b1, 5'd1, 5'd2, 5'd3, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    idle(2);
    // long unacknowledged requests drive the counter into saturation
    for (int i = 0; i < 14; i++) cyc(1'b0, 5'd1, 5'd2, 5'd3, 1'b0, 1'b0, i[0], 1'b1, 1'b0);
    idle(1);
    // random mix
    for (int i = 0; i < 60; i++)
      cyc(($urandom_range(0, 19) == 0), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
          5'($urandom_range(0, 3)), 1'($urandom), 1'($urandom), ($urandom_range(0, 3) == 0),
          ($urandom_range(0, 2) == 0), ($urandom_range(0, 3) == 0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
